// File: rtl/instruction_datapath_pkg.sv
// Shared widths, opcode values and instruction field positions used by the
// datapath and by every initiator that builds instruction words.
package instruction_datapath_pkg;

    localparam int DEF_MEM_ADDR_WIDTH    = 16;
    localparam int DEF_RESULT_WIDTH      = 16;
    localparam int DEF_INSTRUCTION_WIDTH = 32;

    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 28;
    localparam int DATA_HI    = 27;
    localparam int DATA_LO    = 16;
    localparam int ADDR_HI    = 15;
    localparam int ADDR_LO    = 0;
    localparam int ENABLE_BIT = 18;
    localparam int COLOUR_HI  = 17;
    localparam int COLOUR_LO  = 15;
    localparam int Y_HI       = 14;
    localparam int Y_LO       = 8;
    localparam int X_HI       = 7;
    localparam int X_LO       = 0;

    typedef enum logic [3:0] {
        OPC_NOP   = 4'd0,
        OPC_DRAW  = 4'd1,
        OPC_LOAD  = 4'd2,
        OPC_STORE = 4'd3
    } opcode_e;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] address;
        logic [15:0] data;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  colour;
        logic        enable;
    } decoded_t;

endpackage

// File: rtl/instruction_datapath_decode.sv
// Combinational field split of an instruction word into the operands used by
// the datapath.
module instruction_decode
    import instruction_datapath_pkg::*;
(
    input  logic [DEF_INSTRUCTION_WIDTH-1:0] word,
    output decoded_t                         fields
);

    // STORE carries only 12 bits of payload; the upper nibble is zero-filled.
    assign fields.opcode  = word[OPC_HI:OPC_LO];
    assign fields.address = word[ADDR_HI:ADDR_LO];
    assign fields.data    = {4'b0000, word[DATA_HI:DATA_LO]};
    assign fields.x       = word[X_HI:X_LO];
    assign fields.y       = word[Y_HI:Y_LO];
    assign fields.colour  = word[COLOUR_HI:COLOUR_LO];
    assign fields.enable  = word[ENABLE_BIT];

endmodule

// File: rtl/instruction_datapath.sv
// Single-instruction responder: accepts a request on a rising start edge,
// performs a RAM read/write or a pixel plot, then reports a result.
module instruction_datapath
    import instruction_datapath_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH    = DEF_MEM_ADDR_WIDTH,
    parameter int RESULT_WIDTH      = DEF_RESULT_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         finished,
    output logic [RESULT_WIDTH-1:0]      result,
    output logic [MEM_ADDR_WIDTH-1:0]    mem_address,
    output logic [RESULT_WIDTH-1:0]      mem_data,
    output logic                         mem_wren,
    input  logic [RESULT_WIDTH-1:0]      mem_q,
    output logic [7:0]                   vga_x,
    output logic [6:0]                   vga_y,
    output logic [2:0]                   vga_colour,
    output logic                         vga_plot
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_CAPTURE,
        S_WR,
        S_PLOT,
        S_DONE
    } state_e;

    state_e   state;
    logic     start_q;
    decoded_t dec;

    instruction_decode u_decode (
        .word   (instruction),
        .fields (dec)
    );

    always_ff @(posedge clock) begin
        // start_q keeps tracking start during reset so that a start held
        // across reset release is not mistaken for a fresh request.
        start_q <= start;
        if (!resetn) begin
            state       <= S_IDLE;
            finished    <= 1'b1;
            result      <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !start_q) begin
                        finished <= 1'b0;
                        case (dec.opcode)
                            OPC_LOAD: begin
                                mem_address <= dec.address;
                                state       <= S_RD_WAIT;
                            end
                            OPC_STORE: begin
                                mem_address <= dec.address;
                                mem_data    <= dec.data;
                                mem_wren    <= 1'b1;
                                state       <= S_WR;
                            end
                            OPC_DRAW: begin
                                vga_x      <= dec.x;
                                vga_y      <= dec.y;
                                vga_colour <= dec.colour;
                                vga_plot   <= dec.enable;
                                state      <= S_PLOT;
                            end
                            default: state <= S_DONE;
                        endcase
                    end
                end
                // RAM needs one edge to sample the address before mem_q is valid.
                S_RD_WAIT: state <= S_RD_CAPTURE;
                S_RD_CAPTURE: begin
                    result   <= mem_q;
                    finished <= 1'b1;
                    state    <= S_IDLE;
                end
                S_WR: begin
                    mem_wren <= 1'b0;
                    result   <= '0;
                    finished <= 1'b1;
                    state    <= S_IDLE;
                end
                S_PLOT: begin
                    vga_plot <= 1'b0;
                    result   <= '0;
                    finished <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    result   <= '0;
                    finished <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
